// File: rtl/core_control_types.sv
// Shared control types for the multi-cycle core sequencer: FSM state,
// writeback mux select and halt cause encodings.
package core_control_types;
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
  } core_state_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2
  } wb_sel_t;

  typedef enum logic [1:0] {
    HC_NONE     = 2'd0,
    HC_SYSTEM   = 2'd1,
    HC_ILLEGAL  = 2'd2,
    HC_MISALIGN = 2'd3
  } halt_cause_t;
endpackage

// File: rtl/opcodes_pkg.sv
// RV32I major opcode constants (instr[6:0]) shared by decode and control logic.
package opcodes_pkg;
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;
endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC resolution.
// Ports: pc (current pc), valE (live execute result), valE_q (latched execute
// result), cond (branch taken), wb_phase (1 = use valE_q, i.e. in WRITEBACK),
// opcode -> next_pc, misaligned (selected target has nonzero [1:0]).
module next_pc_calc
  import opcodes_pkg::*;
#(
  parameter int XLEN = 32
)(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] valE,
  input  logic [XLEN-1:0] valE_q,
  input  logic            cond,
  input  logic            wb_phase,
  input  logic [6:0]      opcode,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] seq_pc;

  // Jumps are checked in EXECUTE (live valE) so rf_we can be registered
  // already suppressed, and re-evaluated in WRITEBACK from the latched copy.
  assign tgt    = wb_phase ? valE_q : valE;
  assign seq_pc = pc + XLEN'(4);

  always_comb begin
    next_pc    = seq_pc;
    misaligned = 1'b0;
    case (opcode)
      OPC_BRANCH: if (cond) begin
        next_pc    = tgt;
        misaligned = |tgt[1:0];
      end
      OPC_JAL: begin
        next_pc    = tgt;
        misaligned = |tgt[1:0];
      end
      OPC_JALR: begin
        next_pc    = {tgt[XLEN-1:1], 1'b0};
        misaligned = tgt[1];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the single-issue RV32I core.
// Fetches over a req/ack imem port, steps FETCH/DECODE/EXECUTE/MEMORY/
// WRITEBACK, owns the pc, drives dmem requests, rf write strobe, writeback
// select, a 64-bit retired-instruction counter and sticky halt status.
// Ports: clk, rst_n (async low); imem_req/addr/ack/rdata; instr, pc to the
// datapath; valE, cond from execute; dmem_req/we/addr/ack; rf_we, wb_sel;
// instret, halted, halt_cause.
module core_sequencer
  import opcodes_pkg::*;
  import core_control_types::*;
#(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
)(
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] valE,
  input  logic            cond,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  input  logic            dmem_ack,
  output logic            rf_we,
  output logic [1:0]      wb_sel,
  output logic [63:0]     instret,
  output logic            halted,
  output logic [1:0]      halt_cause
);
  core_state_t     state;
  wb_sel_t         wb_sel_q;
  halt_cause_t     cause_q;
  logic [XLEN-1:0] pc_q, valE_q, npc;
  logic [ILEN-1:0] instr_q;
  logic [63:0]     instret_q;
  logic            npc_mis;
  logic [6:0]      opcode;
  logic            rd_nz;

  assign opcode = instr_q[6:0];
  assign rd_nz  = |instr_q[11:7];

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  next_pc_calc #(.XLEN(XLEN)) u_next_pc (
    .pc        (pc_q),
    .valE      (valE),
    .valE_q    (valE_q),
    .cond      (cond),
    .wb_phase  (state == S_WRITEBACK),
    .opcode    (opcode),
    .next_pc   (npc),
    .misaligned(npc_mis)
  );

  // Every strobe is its own flop, set on the transition into the state that
  // owns it, so outputs never glitch. After reset the first FETCH cycle only
  // raises imem_req; later FETCH entries raise it on the transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      valE_q    <= '0;
      instret_q <= '0;
      imem_req  <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
      rf_we     <= 1'b0;
      halted    <= 1'b0;
      wb_sel_q  <= WB_ALU;
      cause_q   <= HC_NONE;
    end else begin
      rf_we <= 1'b0;
      case (state)
        S_FETCH: begin
          if (!imem_req) imem_req <= 1'b1;
          else if (imem_ack) begin
            instr_q  <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (opcode == OPC_SYSTEM) begin
            state <= S_HALT; halted <= 1'b1; cause_q <= HC_SYSTEM;
          end else if (!is_legal(opcode)) begin
            state <= S_HALT; halted <= 1'b1; cause_q <= HC_ILLEGAL;
          end else state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          valE_q <= valE;
          case (opcode)
            OPC_BRANCH: begin
              if (npc_mis) begin
                state <= S_HALT; halted <= 1'b1; cause_q <= HC_MISALIGN;
              end else begin
                pc_q      <= npc;
                instret_q <= instret_q + 64'd1;
                imem_req  <= 1'b1;
                state     <= S_FETCH;
              end
            end
            OPC_LOAD, OPC_STORE: begin
              dmem_req <= 1'b1;
              dmem_we  <= (opcode == OPC_STORE);
              state    <= S_MEMORY;
            end
            default: begin
              rf_we    <= rd_nz && !npc_mis;
              wb_sel_q <= (opcode == OPC_JAL || opcode == OPC_JALR) ? WB_LINK : WB_ALU;
              state    <= S_WRITEBACK;
            end
          endcase
        end
        S_MEMORY: begin
          if (dmem_req && dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (opcode == OPC_STORE) begin
              pc_q      <= npc;
              instret_q <= instret_q + 64'd1;
              imem_req  <= 1'b1;
              state     <= S_FETCH;
            end else begin
              rf_we    <= rd_nz;
              wb_sel_q <= WB_MEM;
              state    <= S_WRITEBACK;
            end
          end
        end
        S_WRITEBACK: begin
          if (npc_mis) begin
            state <= S_HALT; halted <= 1'b1; cause_q <= HC_MISALIGN;
          end else begin
            pc_q      <= npc;
            instret_q <= instret_q + 64'd1;
            imem_req  <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_HALT: ;
        default: state <= S_HALT;
      endcase
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign instr      = instr_q;
  assign dmem_addr  = valE_q;
  assign instret    = instret_q;
  assign wb_sel     = wb_sel_q;
  assign halt_cause = cause_q;
endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer. Expected writebacks (wb_sel per
// rf_we pulse) are queued when an instruction is issued and popped by a
// monitor when rf_we appears; other results are compared inline per test.
module tb_core_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0, instr, pc, valE = '0, dmem_addr;
  logic        cond = 1'b0, dmem_req, dmem_we, dmem_ack = 1'b0, rf_we, halted;
  logic [1:0]  wb_sel, halt_cause;
  logic [63:0] instret;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [1:0]  exp_wb[$];
  logic [1:0]  wb_e;

  always #5 clk = ~clk;

  core_sequencer #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .pc(pc), .valE(valE), .cond(cond),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .wb_sel(wb_sel), .instret(instret),
    .halted(halted), .halt_cause(halt_cause)
  );

  // Scoreboard consumer: every rf_we pulse must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      n_checks++;
      if (exp_wb.size() == 0) begin
        n_fail++;
        $display("FAIL rf_we_unexpected: got rf_we=1 wb_sel=%0d, want no write", wb_sel);
      end else begin
        wb_e = exp_wb.pop_front();
        if (wb_sel !== wb_e) begin
          n_fail++;
          $display("FAIL wb_sel: got %0d, want %0d", wb_sel, wb_e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at a negedge with rst_n released.
  task automatic apply_reset();
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] ins);
    int k = 0;
    while (!imem_req && k < 50) begin @(negedge clk); k++; end
    n_checks++;
    if (!imem_req) begin
      n_fail++;
      $display("FAIL fetch_timeout: got imem_req=0 after %0d cycles, want 1", k);
    end else begin
      imem_rdata = ins; imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!imem_req && !halted && cyc < 50);
    n_checks++;
    if (!imem_req && !halted) begin
      n_fail++;
      $display("FAIL done_timeout: got no fetch/halt after %0d cycles, want one", cyc);
    end
  endtask

  task automatic mem_access(input int lat, output int n, output logic we,
                            output logic [31:0] addr, output logic stable);
    int k = 0;
    n = 0; stable = 1'b1;
    while (!dmem_req && k < 50) begin @(negedge clk); k++; end
    we = dmem_we; addr = dmem_addr;
    while (dmem_req && n < 50) begin
      n++;
      if (dmem_we !== we || dmem_addr !== addr) stable = 1'b0;
      dmem_ack = (n == lat + 1);
      @(negedge clk);
    end
    dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({imem_req, dmem_req, dmem_we, rf_we, halted, wb_sel, halt_cause} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b, want 0", {imem_req, dmem_req, dmem_we, rf_we, halted, wb_sel, halt_cause});
    end
    n_checks++;
    if (pc !== 32'h0 || instret !== 64'h0 || instr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: got pc=%h instret=%0d instr=%h, want 0 0 0", pc, instret, instr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_fetch: got imem_req=%b addr=%h, want 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_alu();
    int c;
    exp_wb.push_back(2'd0);
    valE = 32'd5; cond = 1'b0;
    fetch(32'h0050_0093);
    wait_done(c);
    n_checks++;
    if (c !== 3) begin n_fail++; $display("FAIL alu_cycles: got %0d, want 3 after fetch", c); end
    n_checks++;
    if (pc !== 32'h4 || instret !== 64'd1 || instr !== 32'h0050_0093) begin
      n_fail++;
      $display("FAIL alu_retire: got pc=%h instret=%0d instr=%h, want 4 1 00500093", pc, instret, instr);
    end
  endtask

  task automatic test_branch();
    int c;
    exp_wb.push_back(2'd2);
    valE = 32'h10; fetch(32'h0000_00EF); wait_done(c);   // jal x1
    n_checks++;
    if (pc !== 32'h10 || instret !== 64'd2) begin
      n_fail++; $display("FAIL jal_pc: got pc=%h instret=%0d, want 10 2", pc, instret);
    end
    valE = 32'h20; cond = 1'b1; fetch(32'h0000_0863); wait_done(c);
    n_checks++;
    if (pc !== 32'h20 || instret !== 64'd3 || c !== 2) begin
      n_fail++; $display("FAIL beq_taken: got pc=%h instret=%0d cyc=%0d, want 20 3 2", pc, instret, c);
    end
    cond = 1'b0; valE = 32'h10; fetch(32'h0000_006F); wait_done(c);   // jal x0
    valE = 32'h20; fetch(32'h0000_0863); wait_done(c);
    n_checks++;
    if (pc !== 32'h14 || instret !== 64'd5) begin
      n_fail++; $display("FAIL beq_not_taken: got pc=%h instret=%0d, want 14 5", pc, instret);
    end
  endtask

  task automatic test_load_store();
    int c, n;
    logic we, st;
    logic [31:0] a;
    valE = 32'h100;
    fetch(32'h0020_A023);   // sw x2,0(x1)
    mem_access(0, n, we, a, st);
    wait_done(c);
    n_checks++;
    if (n !== 1 || we !== 1'b1 || a !== 32'h100 || !st) begin
      n_fail++; $display("FAIL store_req: got len=%0d we=%b addr=%h stable=%b, want 1 1 100 1", n, we, a, st);
    end
    n_checks++;
    if (pc !== 32'h18 || instret !== 64'd6) begin
      n_fail++; $display("FAIL store_retire: got pc=%h instret=%0d, want 18 6", pc, instret);
    end
    exp_wb.push_back(2'd1);
    fetch(32'h0000_A103);   // lw x2,0(x1)
    mem_access(3, n, we, a, st);
    wait_done(c);
    n_checks++;
    if (n !== 4 || we !== 1'b0 || a !== 32'h100 || !st) begin
      n_fail++; $display("FAIL load_req: got len=%0d we=%b addr=%h stable=%b, want 4 0 100 1", n, we, a, st);
    end
    n_checks++;
    if (pc !== 32'h1C || instret !== 64'd7) begin
      n_fail++; $display("FAIL load_retire: got pc=%h instret=%0d, want 1c 7", pc, instret);
    end
  endtask

  task automatic test_pc_wrap();
    int c;
    valE = 32'hFFFF_FFFC; fetch(32'h0000_006F); wait_done(c);
    n_checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_jump: got imem_addr=%h, want fffffffc", imem_addr);
    end
    exp_wb.push_back(2'd0);
    valE = 32'd9; fetch(32'h0050_0093); wait_done(c);
    n_checks++;
    if (pc !== 32'h0 || instret !== 64'd9) begin
      n_fail++; $display("FAIL wrap_pc: got pc=%h instret=%0d, want 0 9", pc, instret);
    end
  endtask

  task automatic test_halt_jalr();
    int c;
    apply_reset();
    cond = 1'b0; valE = 32'h103;
    fetch(32'h0001_00E7);   // jalr x1,0(x2)
    wait_done(c);
    n_checks++;
    if (halted !== 1'b1 || halt_cause !== 2'd3 || pc !== 32'h0 || instret !== 64'd0) begin
      n_fail++; $display("FAIL jalr_misalign: got halted=%b cause=%0d pc=%h instret=%0d, want 1 3 0 0",
                         halted, halt_cause, pc, instret);
    end
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1; dmem_ack = 1'b1; imem_rdata = 32'h0050_0093;
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b0 || dmem_req !== 1'b0 || halted !== 1'b1 || pc !== 32'h0 ||
          instret !== 64'd0 || instr !== 32'h0001_00E7 || halt_cause !== 2'd3) begin
        n_fail++; $display("FAIL halt_frozen: got req=%b%b halted=%b pc=%h instret=%0d instr=%h cause=%0d",
                           imem_req, dmem_req, halted, pc, instret, instr, halt_cause);
      end
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic test_halt_causes();
    int c;
    apply_reset(); fetch(32'h0000_007F); wait_done(c);
    n_checks++;
    if (halted !== 1'b1 || halt_cause !== 2'd2) begin
      n_fail++; $display("FAIL illegal: got halted=%b cause=%0d, want 1 2", halted, halt_cause);
    end
    apply_reset(); fetch(32'h0000_0073); wait_done(c);
    n_checks++;
    if (halted !== 1'b1 || halt_cause !== 2'd1) begin
      n_fail++; $display("FAIL ecall: got halted=%b cause=%0d, want 1 1", halted, halt_cause);
    end
    apply_reset(); cond = 1'b1; valE = 32'h22; fetch(32'h0000_0863); wait_done(c);
    n_checks++;
    if (halted !== 1'b1 || halt_cause !== 2'd3 || pc !== 32'h0 || instret !== 64'd0) begin
      n_fail++; $display("FAIL branch_misalign: got halted=%b cause=%0d pc=%h instret=%0d, want 1 3 0 0",
                         halted, halt_cause, pc, instret);
    end
    cond = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int c, k;
    apply_reset();
    k = 0;
    while (!imem_req && k < 50) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL rst_fetch_drop: got imem_req=%b, want 0", imem_req);
    end
    @(negedge clk); rst_n = 1'b1;
    exp_wb.push_back(2'd0);
    valE = 32'd5; fetch(32'h0050_0093); wait_done(c);
    valE = 32'h100; fetch(32'h0000_A103);
    k = 0;
    while (!dmem_req && k < 50) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || pc !== 32'h0 || instret !== 64'd0) begin
      n_fail++; $display("FAIL rst_mem_drop: got dmem_req=%b we=%b pc=%h instret=%0d, want 0 0 0 0",
                         dmem_req, dmem_we, pc, instret);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instret !== 64'd0) begin
      n_fail++; $display("FAIL rst_restart: got imem_req=%b addr=%h instret=%0d, want 1 0 0",
                         imem_req, imem_addr, instret);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_load_store();
    test_pc_wrap();
    test_halt_jalr();
    test_halt_causes();
    test_reset_midflight();
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_wb.size() != 0) begin
      n_fail++; $display("FAIL wb_pending: got %0d writebacks outstanding, want 0", exp_wb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM for the single-issue RV32I core. It fetches each instruction over a req/ack instruction-memory port and steps it through decode, execute, memory and writeback. It owns the PC and consumes the execute stage's valE/cond outputs to resolve branch and jump targets. It also drives data-memory requests, register-file write enables, the writeback mux select, a retired-instruction counter and halt status.

Parameters:
XLEN, 32, datapath width
ILEN, 32, instruction width
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  instruction fetch request
imem_addr  out  XLEN  fetch address (equals pc)
imem_ack  in  1  fetch data valid; sampled only while imem_req=1
imem_rdata  in  ILEN  fetched instruction
instr  out  ILEN  latched instruction, fed to decode/execute
pc  out  XLEN  current instruction address, fed to execute
valE  in  XLEN  execute-stage result
cond  in  1  execute-stage branch condition
dmem_req  out  1  data memory request
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  XLEN  data address (latched valE)
dmem_ack  in  1  data access complete; sampled only while dmem_req=1
rf_we  out  1  register-file write strobe
wb_sel  out  2  writeback source: 0 ALU (latched valE), 1 MEM, 2 LINK (pc+4)
instret  out  64  retired-instruction count
halted  out  1  core stopped (sticky)
halt_cause  out  2  0 none, 1 ECALL/EBREAK, 2 illegal opcode, 3 misaligned target

Behaviour:
- Reset (async, rst_n=0) values:
  - state=FETCH, pc=RESET_PC, instr=0, instret=0.
  - imem_req, dmem_req, dmem_we, rf_we, halted all 0; wb_sel=0; halt_cause=0.
  - All requests drop immediately on reset assertion, including mid-transaction.
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc, held until imem_ack.
  - On ack: instr<=imem_rdata, go to DECODE; imem_req is 0 in DECODE.
  - Zero-wait ack in the first FETCH cycle is legal.
- DECODE (1 cycle):
  - opcode=instr[6:0].
  - SYSTEM -> HALT, cause 1.
  - Opcode outside {OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, SYSTEM} -> HALT, cause 2.
  - Otherwise go to EXECUTE.
- EXECUTE (1 cycle):
  - valE_q<=valE.
  - BRANCH: cond=1 and valE[1:0]!=0 -> HALT, cause 3, pc unchanged. cond=1 otherwise -> pc<=valE. cond=0 -> pc<=pc+4. Retire, go to FETCH.
  - LOAD/STORE -> MEMORY.
  - Everything else -> WRITEBACK.
- MEMORY:
  - dmem_req=1, dmem_addr=valE_q, dmem_we=(opcode==STORE), held until dmem_ack.
  - On ack: STORE -> pc<=pc+4, retire, go to FETCH. LOAD -> WRITEBACK.
- WRITEBACK (1 cycle):
  - rf_we=1 unless instr[11:7]==0.
  - wb_sel: MEM for LOAD, LINK for JAL/JALR, ALU otherwise.
  - Next pc: JAL -> valE_q. JALR -> valE_q with bit0 cleared. Other opcodes -> pc+4.
  - If the jump target [1:0]!=0: HALT, cause 3, rf_we suppressed, pc unchanged.
  - Otherwise retire, go to FETCH.
- HALT:
  - halted=1; all requests and rf_we low; pc, instret and halt_cause frozen.
  - Exit only via reset.
- Retire: instret increments by 1 in the cycle an instruction completes; 64-bit, wraps to 0.
- Arithmetic: pc+4 is modulo 2^XLEN; wrap from 32'hFFFF_FFFC to 0 is legal.
- Acks with the corresponding request low are ignored.
- rf_we and the request strobes are registered-state decodes and must be glitch-free.

Decomposition:
- State enum (core_state_t), wb_sel enum (wb_sel_t) and halt_cause enum go in a shared package core_control_types.
- Opcode constants come from the existing opcodes package.
- One sub-module, next_pc_calc (combinational): inputs pc, valE/valE_q, cond, opcode; outputs next pc and misaligned flag.
- The FSM and counters stay in core_sequencer.

Test Plan:
- Reset, then instr 32'h00500093 (addi x1,x0,5), zero-wait imem_ack, valE=5 -> FETCH, DECODE, EXECUTE, WRITEBACK in 4 cycles; one rf_we pulse with wb_sel=ALU; pc=4; instret=1.
- pc=0x10, instr 32'h00000863 (beq), valE=0x20. cond=1 -> pc=0x20, no rf_we, instret+1. Repeat with cond=0 -> pc=0x14.
- Load (lw x2,0(x1)), valE=0x100, dmem_ack 3 cycles after request -> dmem_req high for 4 cycles, dmem_we=0, dmem_addr=0x100, then rf_we with wb_sel=MEM, pc+=4.
- JALR with valE=0x103 -> bit0 cleared gives 0x102, misaligned -> halted=1, cause=3, rf_we never asserted, pc unchanged. Later imem_ack pulses are ignored.
- Illegal instr 32'h0000007F -> HALT, cause=2. Instr 32'h00000073 (ecall) -> HALT, cause=1.
- rst_n dropped during a FETCH wait and during a MEMORY wait -> imem_req/dmem_req fall the same cycle; after release, state=FETCH, pc=RESET_PC, instret=0.
